riscv_top: RTL and testbench

RISCV_TOP -- requirements
Module: riscv_top

---
 rtl/riscv_pkg.sv | 61 ++++++
 rtl/riscv_alu.sv | 42 ++++
 rtl/riscv_top.sv | 218 +++++++++++++++++++++
 tb/tb_riscv_top.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the single-cycle RV32I-subset core: opcodes, funct fields,
// ALU operation enum and the memory-mapped output register address.
package riscv_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_JALR = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [31:0] OUTPORT_ADDR = 32'h0000_FFFC;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_t;

   // alt selects SUB/SRA where funct7 carries the alternate encoding
   function automatic alu_op_t alu_op_decode(input logic [2:0] f3, input logic alt);
      alu_op_t op;
      case (f3)
         F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  op = ALU_SLL;
         F3_SLT:  op = ALU_SLT;
         F3_SLTU: op = ALU_SLTU;
         F3_XOR:  op = ALU_XOR;
         F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   op = ALU_OR;
         F3_AND:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/riscv_alu.sv
// Combinational ALU: computes the selected operation and the three compare
// flags used by conditional branches.
module riscv_alu
   import riscv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  alu_op_t          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             eq,
   output logic             lt,
   output logic             ltu
);

   logic [4:0] shamt_s;

   assign shamt_s = b[4:0];
   assign eq      = (a == b);
   assign lt      = ($signed(a) < $signed(b));
   assign ltu     = (a < b);

   // Result multiplexer
   always_comb begin
      result = a + b;
      case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLL:  result = a << shamt_s;
         ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt};
         ALU_SLTU: result = {{(WIDTH-1){1'b0}}, ltu};
         ALU_XOR:  result = a ^ b;
         ALU_SRL:  result = a >> shamt_s;
         ALU_SRA:  result = $unsigned($signed(a) >>> shamt_s);
         ALU_OR:   result = a | b;
         ALU_AND:  result = a & b;
         default:  result = a + b;
      endcase
   end

endmodule

// File: rtl/riscv_top.sv
// Single-cycle RV32I-subset core with unified async-read memory, flash load
// port and one memory-mapped output register at OUTPORT_ADDR.
module riscv_top
   import riscv_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MEM_WORDS = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] flash_addr,
   input  logic [WIDTH-1:0] flash_data,
   input  logic             flash_en,
   output logic [WIDTH-1:0] outport
);

   localparam int AW = $clog2(MEM_WORDS);

   logic [WIDTH-1:0] mem_r  [MEM_WORDS];
   logic [WIDTH-1:0] regs_r [32];
   logic [WIDTH-1:0] pc_r;
   logic [WIDTH-1:0] outport_r;

   logic [31:0]      instr_s;
   logic [6:0]       opcode_s;
   logic [6:0]       funct7_s;
   logic [2:0]       funct3_s;
   logic [4:0]       rd_s;
   logic [4:0]       rs1_s;
   logic [4:0]       rs2_s;
   logic [WIDTH-1:0] i_imm_s;
   logic [WIDTH-1:0] s_imm_s;
   logic [WIDTH-1:0] b_imm_s;
   logic [WIDTH-1:0] u_imm_s;
   logic [WIDTH-1:0] j_imm_s;
   logic [WIDTH-1:0] rs1_val_s;
   logic [WIDTH-1:0] rs2_val_s;
   logic [WIDTH-1:0] alu_b_s;
   logic [WIDTH-1:0] alu_res_s;
   alu_op_t          alu_op_s;
   logic             alu_eq_s;
   logic             alu_lt_s;
   logic             alu_ltu_s;
   logic [WIDTH-1:0] data_word_s;
   logic [WIDTH-1:0] pc_plus4_s;
   logic [WIDTH-1:0] jalr_sum_s;
   logic [WIDTH-1:0] pc_next_s;
   logic [WIDTH-1:0] rd_data_s;
   logic             rd_we_s;
   logic             mem_we_s;
   logic             out_we_s;
   logic             taken_s;
   logic             is_mmio_s;
   logic             imm_ok_s;
   logic             reg_ok_s;
   logic             unused_s;

   assign instr_s   = mem_r[pc_r[AW+1:2]];
   assign opcode_s  = instr_s[6:0];
   assign rd_s      = instr_s[11:7];
   assign funct3_s  = instr_s[14:12];
   assign rs1_s     = instr_s[19:15];
   assign rs2_s     = instr_s[24:20];
   assign funct7_s  = instr_s[31:25];

   assign i_imm_s = {{20{instr_s[31]}}, instr_s[31:20]};
   assign s_imm_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
   assign b_imm_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
   assign u_imm_s = {instr_s[31:12], 12'd0};
   assign j_imm_s = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};

   assign rs1_val_s = (rs1_s == 5'd0) ? 32'd0 : regs_r[rs1_s];
   assign rs2_val_s = (rs2_s == 5'd0) ? 32'd0 : regs_r[rs2_s];

   assign pc_plus4_s  = pc_r + 32'd4;
   assign jalr_sum_s  = pc_r + alu_res_s;
   assign data_word_s = mem_r[alu_res_s[AW+1:2]];
   assign is_mmio_s   = (alu_res_s == OUTPORT_ADDR);
   assign outport     = outport_r;

   // Encodings outside these funct7 patterns are not RV32I and retire as NOPs
   assign imm_ok_s = (funct3_s == F3_SLL) ? (funct7_s == F7_BASE) :
                     (funct3_s == F3_SR)  ? ((funct7_s == F7_BASE) || (funct7_s == F7_ALT)) :
                     1'b1;
   assign reg_ok_s = (funct7_s == F7_BASE) ||
                     ((funct7_s == F7_ALT) && ((funct3_s == F3_ADD) || (funct3_s == F3_SR)));

   assign unused_s = ^{flash_addr[WIDTH-1:AW+2], flash_addr[1:0]};

   riscv_alu #(.WIDTH(WIDTH)) u_alu (
      .op     (alu_op_s),
      .a      (rs1_val_s),
      .b      (alu_b_s),
      .result (alu_res_s),
      .eq     (alu_eq_s),
      .lt     (alu_lt_s),
      .ltu    (alu_ltu_s)
   );

   // ALU operand and operation select
   always_comb begin
      alu_b_s  = rs2_val_s;
      alu_op_s = ALU_ADD;
      case (opcode_s)
         OP_IMM: begin
            alu_b_s  = i_imm_s;
            alu_op_s = alu_op_decode(funct3_s, (funct3_s == F3_SR) && (funct7_s == F7_ALT));
         end
         OP_REG:           alu_op_s = alu_op_decode(funct3_s, funct7_s == F7_ALT);
         OP_LOAD, OP_JALR: alu_b_s  = i_imm_s;
         OP_STORE:         alu_b_s  = s_imm_s;
         default: begin
            alu_b_s  = rs2_val_s;
            alu_op_s = ALU_ADD;
         end
      endcase
   end

   // Instruction effects: next PC, register writeback and store routing
   always_comb begin
      pc_next_s = pc_plus4_s;
      rd_data_s = alu_res_s;
      rd_we_s   = 1'b0;
      mem_we_s  = 1'b0;
      out_we_s  = 1'b0;
      taken_s   = 1'b0;
      case (opcode_s)
         OP_LUI: begin
            rd_we_s   = 1'b1;
            rd_data_s = u_imm_s;
         end
         OP_AUIPC: begin
            rd_we_s   = 1'b1;
            rd_data_s = pc_r + u_imm_s;
         end
         OP_JAL: begin
            rd_we_s   = 1'b1;
            rd_data_s = pc_plus4_s;
            pc_next_s = pc_r + j_imm_s;
         end
         OP_JALR: begin
            // Target deliberately includes PC: PC + rs1 + imm, bit 0 cleared
            if (funct3_s == F3_JALR) begin
               rd_we_s   = 1'b1;
               rd_data_s = pc_plus4_s;
               pc_next_s = {jalr_sum_s[WIDTH-1:1], 1'b0};
            end else begin
               rd_we_s = 1'b0;
            end
         end
         OP_BRANCH: begin
            case (funct3_s)
               F3_BEQ:  taken_s = alu_eq_s;
               F3_BNE:  taken_s = !alu_eq_s;
               F3_BLT:  taken_s = alu_lt_s;
               F3_BGE:  taken_s = !alu_lt_s;
               F3_BLTU: taken_s = alu_ltu_s;
               F3_BGEU: taken_s = !alu_ltu_s;
               default: taken_s = 1'b0;
            endcase
            pc_next_s = taken_s ? (pc_r + b_imm_s) : pc_plus4_s;
         end
         OP_LOAD: begin
            if (funct3_s == F3_WORD) begin
               rd_we_s   = 1'b1;
               rd_data_s = is_mmio_s ? outport_r : data_word_s;
            end else begin
               rd_we_s = 1'b0;
            end
         end
         OP_STORE: begin
            if (funct3_s == F3_WORD) begin
               out_we_s = is_mmio_s;
               mem_we_s = !is_mmio_s;
            end else begin
               mem_we_s = 1'b0;
            end
         end
         OP_IMM:  rd_we_s = imm_ok_s;
         OP_REG:  rd_we_s = reg_ok_s;
         default: rd_we_s = 1'b0;
      endcase
   end

   // Unified memory write port; flash loads win and work during reset
   always_ff @(posedge clk) begin
      if (flash_en) begin
         mem_r[flash_addr[AW+1:2]] <= flash_data;
      end else if (mem_we_s && !rst) begin
         mem_r[alu_res_s[AW+1:2]] <= rs2_val_s;
      end
   end

   // Register file writeback
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs_r[i] <= 32'd0;
         end
      end else if (rd_we_s && (rd_s != 5'd0)) begin
         regs_r[rd_s] <= rd_data_s;
      end
   end

   // Program counter and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r      <= 32'd0;
         outport_r <= 32'd0;
      end else begin
         pc_r <= pc_next_s;
         if (out_we_s) begin
            outport_r <= rs2_val_s;
         end
      end
   end

endmodule

// File: tb/tb_riscv_top.sv
// Self-checking bench for riscv_top: directed programs plus random programs,
// all compared against an instruction-level reference model.
module tb_riscv_top;

   logic        clk = 1'b0;
   logic        rst;
   logic        flash_en;
   logic [31:0] flash_addr;
   logic [31:0] flash_data;
   logic [31:0] outport;

   always #5 clk = ~clk;

   riscv_top #(.WIDTH(32), .MEM_WORDS(1024)) dut (
      .clk        (clk),
      .rst        (rst),
      .flash_addr (flash_addr),
      .flash_data (flash_data),
      .flash_en   (flash_en),
      .outport    (outport)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] m_mem [1024];
   logic [31:0] m_reg [32];
   logic [31:0] m_pc;
   logic [31:0] m_out;
   logic [31:0] prog [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                         input int rd, input logic [6:0] op);
      logic [31:0] t;
      t = imm;
      return {t[11:0], 5'(rs1), f3, 5'(rd), op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                         input logic [2:0] f3, input int rd);
      return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
      logic [31:0] t;
      t = imm;
      return {t[11:5], 5'(rs2), 5'(rs1), 3'b010, t[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
      logic [31:0] t;
      t = imm20;
      return {t[19:0], 5'(rd), op};
   endfunction

   function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
      logic [31:0] t;
      t = imm;
      return {t[12], t[10:5], 5'(rs2), 5'(rs1), f3, t[4:1], t[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_j(input int imm, input int rd);
      logic [31:0] t;
      t = imm;
      return {t[20], t[10:1], t[11], t[19:12], 5'(rd), 7'h6f};
   endfunction

   function automatic void model_reset();
      m_pc  = 32'd0;
      m_out = 32'd0;
      for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
   endfunction

   // Architectural effect of one instruction, straight from the ISA rules
   function automatic void model_step();
      logic [31:0] ins, a, b, ii, si, bi, ui, ji, nxt, ea, res;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [4:0]  sh;
      logic        wr, ok, tk;
      ins = m_mem[m_pc[11:2]];
      f3  = ins[14:12];
      f7  = ins[31:25];
      a   = m_reg[ins[19:15]];
      b   = m_reg[ins[24:20]];
      ii  = {{20{ins[31]}}, ins[31:20]};
      si  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      bi  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      ui  = {ins[31:12], 12'd0};
      ji  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      nxt = m_pc + 32'd4;
      wr  = 1'b0;
      res = 32'd0;
      case (ins[6:0])
         7'h37: begin wr = 1'b1; res = ui; end
         7'h17: begin wr = 1'b1; res = m_pc + ui; end
         7'h6f: begin wr = 1'b1; res = m_pc + 32'd4; nxt = m_pc + ji; end
         7'h67: if (f3 == 3'd0) begin
            wr = 1'b1; res = m_pc + 32'd4; nxt = (m_pc + a + ii) & 32'hFFFF_FFFE;
         end
         7'h63: begin
            case (f3)
               3'd0: tk = (a == b);
               3'd1: tk = (a != b);
               3'd4: tk = ($signed(a) < $signed(b));
               3'd5: tk = ($signed(a) >= $signed(b));
               3'd6: tk = (a < b);
               3'd7: tk = (a >= b);
               default: tk = 1'b0;
            endcase
            if (tk) nxt = m_pc + bi;
         end
         7'h03: if (f3 == 3'd2) begin
            ea = a + ii; wr = 1'b1;
            res = (ea == 32'h0000_FFFC) ? m_out : m_mem[ea[11:2]];
         end
         7'h23: if (f3 == 3'd2) begin
            ea = a + si;
            if (ea == 32'h0000_FFFC) m_out = b; else m_mem[ea[11:2]] = b;
         end
         7'h13, 7'h33: begin
            if (ins[6:0] == 7'h13) begin
               b  = ii;
               ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                    (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            end else begin
               ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            sh = b[4:0];
            case (f3)
               3'd0: res = (ins[6:0] == 7'h33 && f7 == 7'h20) ? a - b : a + b;
               3'd1: res = a << sh;
               3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               3'd3: res = (a < b) ? 32'd1 : 32'd0;
               3'd4: res = a ^ b;
               3'd5: res = (f7 == 7'h20) ? $unsigned($signed(a) >>> sh) : a >> sh;
               3'd6: res = a | b;
               default: res = a & b;
            endcase
            wr = ok;
         end
         default: wr = 1'b0;
      endcase
      if (wr && ins[11:7] != 5'd0) m_reg[ins[11:7]] = res;
      m_pc = nxt;
   endfunction

   task automatic flash_word(input logic [31:0] addr, input logic [31:0] data);
      flash_en   = 1'b1;
      flash_addr = addr;
      flash_data = data;
      @(negedge clk);
      flash_en = 1'b0;
      m_mem[addr[11:2]] = data;
   endtask

   // Holds reset, loads prog at address 0 and checks the reset state
   task automatic load_prog(input string tag);
      rst = 1'b1;
      foreach (prog[i]) flash_word(32'(i * 4), prog[i]);
      @(negedge clk);
      model_reset();
      check_eq({tag, "_rst_pc"}, dut.pc_r, 32'd0);
      check_eq({tag, "_rst_out"}, outport, 32'd0);
      rst = 1'b0;
   endtask

   task automatic run(input string tag, input int n);
      repeat (n) begin
         @(negedge clk);
         model_step();
         check_eq({tag, "_pc"}, dut.pc_r, m_pc);
      end
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 32; i++)
         check_eq($sformatf("%s_x%0d", tag, i), dut.regs_r[i], m_reg[i]);
   endtask

   task automatic gen_random(input int k);
      int kind, rd, r1, r2, f3;
      prog.delete();
      for (int n = 0; n < k; n++) begin
         kind = $urandom_range(0, 9);
         rd   = $urandom_range(0, 15);
         r1   = $urandom_range(0, 15);
         r2   = $urandom_range(0, 15);
         f3   = $urandom_range(0, 7);
         case (kind)
            0: begin
               if (f3 == 1) prog.push_back(enc_i($urandom_range(0, 31), r1, 3'(f3), rd, 7'h13));
               else if (f3 == 5) prog.push_back(enc_i($urandom_range(0, 1) * 1024 + $urandom_range(0, 31), r1, 3'(f3), rd, 7'h13));
               else prog.push_back(enc_i($urandom_range(0, 4095), r1, 3'(f3), rd, 7'h13));
            end
            1, 2: prog.push_back(enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, r2, r1, 3'(f3), rd));
            3: prog.push_back(enc_u($urandom, rd, 7'h37));
            4: prog.push_back(enc_u($urandom, rd, 7'h17));
            5: prog.push_back(enc_s(1024 + 4 * $urandom_range(0, 255), r2, 0));
            6: prog.push_back(enc_i(1024 + 4 * $urandom_range(0, 255), 0, 3'd2, rd, 7'h03));
            7: prog.push_back(enc_b(8, r2, r1, (f3 == 2 || f3 == 3) ? 3'd0 : 3'(f3)));
            8: prog.push_back(enc_j(8, rd));
            default: prog.push_back($urandom_range(0, 1) == 1 ? enc_i(4, 0, 3'd0, rd, 7'h03) : {25'(rd), 7'h0B});
         endcase
      end
      prog.push_back(enc_j(0, 0));
      prog.push_back(enc_j(0, 0));
   endtask

   initial begin
      rst        = 1'b1;
      flash_en   = 1'b0;
      flash_addr = 32'd0;
      flash_data = 32'd0;
      model_reset();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 1024; i++) flash_word(32'(i * 4), 32'd0);

      // Clear-then-increment loop closed by a PC-relative JALR
      prog = {32'h00c64633, 32'h00160613, 32'hffc00067};
      load_prog("loop");
      run("loop", 50);
      check_eq("loop_x12", dut.regs_r[12], m_reg[12]);
      check_eq("loop_x12_range", 32'(dut.regs_r[12] == 32'd24 || dut.regs_r[12] == 32'd25), 32'd1);

      // Two JALRs bouncing between 0 and 12
      prog = {32'h00c00067, 32'd0, 32'd0, 32'hff400067};
      load_prog("bounce");
      run("bounce", 6);
      check_regs("bounce");

      // Store to the output register must not touch the aliased memory word
      rst = 1'b1;
      flash_word(32'h0000_0FFC, 32'hDEAD_BEEF);
      prog = {enc_u(32'h10, 1, 7'h37), enc_i(-4, 1, 3'd0, 1, 7'h13),
              enc_i(32'h55, 0, 3'd0, 2, 7'h13), enc_s(0, 2, 1)};
      load_prog("mmio");
      run("mmio", 4);
      check_eq("mmio_out", outport, 32'h55);
      check_eq("mmio_w1023", dut.mem_r[1023], 32'hDEAD_BEEF);

      // Shift and unsigned compare corner values
      prog = {enc_i(-1, 0, 3'd0, 1, 7'h13), enc_i(28, 1, 3'd5, 2, 7'h13),
              enc_i(32'h41C, 1, 3'd5, 3, 7'h13), enc_r(7'h00, 1, 0, 3'd3, 4)};
      load_prog("shift");
      run("shift", 4);
      check_eq("shift_x2", dut.regs_r[2], 32'h0000_000F);
      check_eq("shift_x3", dut.regs_r[3], 32'hFFFF_FFFF);
      check_eq("shift_x4", dut.regs_r[4], 32'd1);

      // Store/load round trip, then reset in the middle of the loop
      prog = {enc_i(32'h100, 0, 3'd0, 5, 7'h13), enc_i(32'h5A3, 0, 3'd0, 6, 7'h13),
              enc_u(32'h10, 9, 7'h37), enc_s(-4, 6, 9), enc_s(0, 6, 5),
              enc_i(0, 5, 3'd2, 7, 7'h03), enc_i(1, 8, 3'd0, 8, 7'h13), enc_j(-8, 0)};
      load_prog("sl");
      run("sl", 12);
      check_eq("sl_x7", dut.regs_r[7], 32'h5A3);
      check_eq("sl_out", outport, 32'h5A3);
      check_regs("sl");
      rst = 1'b1;
      @(negedge clk);
      model_reset();
      check_eq("sl_rst_pc", dut.pc_r, 32'd0);
      check_eq("sl_rst_out", outport, 32'd0);
      check_regs("sl_rst");
      check_eq("sl_rst_mem", dut.mem_r[64], 32'h5A3);
      rst = 1'b0;
      run("sl_again", 3);
      check_regs("sl_again");

      // Flash write beats a core store to the same word in the same cycle
      prog = {enc_i(32'h77, 0, 3'd0, 5, 7'h13), enc_s(32'h200, 5, 0), enc_j(0, 0)};
      load_prog("race");
      run("race", 1);
      flash_en   = 1'b1;
      flash_addr = 32'h200;
      flash_data = 32'hCAFE_0000;
      @(negedge clk);
      flash_en = 1'b0;
      model_step();
      m_mem[128] = 32'hCAFE_0000;
      check_eq("race_pc", dut.pc_r, m_pc);
      check_eq("race_mem", dut.mem_r[128], 32'hCAFE_0000);

      // Random programs against the reference model
      for (int t = 0; t < 4; t++) begin
         gen_random(30);
         load_prog($sformatf("rnd%0d", t));
         run($sformatf("rnd%0d", t), 40);
         check_regs($sformatf("rnd%0d", t));
         check_eq($sformatf("rnd%0d_out", t), outport, m_out);
         for (int w = 256; w < 512; w++)
            check_eq($sformatf("rnd%0d_m%0d", t, w), dut.mem_r[w], m_mem[w]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
